// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the ID-stage hazard inputs and the stall/flush sequencer outputs.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int STAT_W     = 16
);
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rt;
    logic                  id_branch_taken;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_start_mul;
    logic                  pc_write;
    logic                  ifid_en;
    logic                  ifid_flush;
    logic                  idex_hold;
    logic                  exmem_bubble;
    logic                  busy;
    logic [STAT_W-1:0]     stall_count;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_branch_taken, ex_mem_read, ex_rd, ex_start_mul,
        input  pc_write, ifid_en, ifid_flush, idex_hold, exmem_bubble, busy, stall_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_branch_taken, ex_mem_read, ex_rd, ex_start_mul,
        output pc_write, ifid_en, ifid_flush, idex_hold, exmem_bubble, busy, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, taken-branch flushes,
// and a fixed-length freeze while a multi-cycle multiply occupies EX.
//   state    | meaning
//   RUN      | normal flow; load-use / branch / multiply start detected here
//   MUL_WAIT | pipeline frozen while the multiply counter runs down
//   RELEASE  | multiply leaving EX; its start flag is ignored this cycle
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int MUL_STALL  = 3,
    parameter int CNT_W      = 3,
    parameter int STAT_W     = 16
) (
    input logic                 clk,
    input logic                 rst,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {RUN, MUL_WAIT, RELEASE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [STAT_W-1:0] stall_count;
    logic              load_use;
    logic              pc_write, ifid_en, ifid_flush, idex_hold, exmem_bubble, busy;

    assign load_use = hz.ex_mem_read && (hz.ex_rd != '0) &&
                      ((hz.ex_rd == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rd == hz.id_rt)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        pc_write     = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_hold    = 1'b0;
        exmem_bubble = 1'b0;
        busy         = (state != RUN);
        if (rst) begin
            pc_write   = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
            busy       = 1'b0;
        end else begin
            case (state)
                RUN, RELEASE: begin
                    if (state == RUN && hz.ex_start_mul) begin
                        pc_write     = 1'b0;
                        ifid_en      = 1'b0;
                        idex_hold    = 1'b1;
                        exmem_bubble = 1'b1;
                        count_nxt    = CNT_W'(MUL_STALL - 2);
                        state_nxt    = MUL_WAIT;
                    end else begin
                        state_nxt = RUN;
                        // Load-use wins over a branch: the branch flushes on the following cycle.
                        if (load_use) begin
                            pc_write = 1'b0;
                            ifid_en  = 1'b0;
                        end else if (hz.id_branch_taken) begin
                            ifid_en    = 1'b0;
                            ifid_flush = 1'b1;
                        end
                    end
                end
                MUL_WAIT: begin
                    pc_write     = 1'b0;
                    ifid_en      = 1'b0;
                    idex_hold    = 1'b1;
                    exmem_bubble = 1'b1;
                    if (count == '0) state_nxt = RELEASE;
                    else             count_nxt = count - CNT_W'(1);
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_count <= '0;
        else if (!pc_write && (stall_count != {STAT_W{1'b1}}))
            stall_count <= stall_count + STAT_W'(1);
    end

    assign hz.pc_write     = pc_write;
    assign hz.ifid_en      = ifid_en;
    assign hz.ifid_flush   = ifid_flush;
    assign hz.idex_hold    = idex_hold;
    assign hz.exmem_bubble = exmem_bubble;
    assign hz.busy         = busy;
    assign hz.stall_count  = stall_count;
endmodule
